// File: rtl/crpa_stap_combiner_if.sv
// rtl/crpa_stap_combiner_if.sv - sample, weight-write and output bundle of the space-time combiner
interface crpa_stap_combiner_if #(
    parameter int Nin       = 8,
    parameter int in_width  = 14,
    parameter int NT        = 4,
    parameter int W_WIDTH   = 16,
    parameter int OUT_WIDTH = 16
);
    localparam int AW = $clog2(Nin * NT);

    logic                                  ena;
    logic [Nin-1:0][NT-1:0][in_width-1:0]  data_dly;
    logic                                  w_wr;
    logic [AW-1:0]                         w_addr;
    logic [W_WIDTH-1:0]                    w_data;
    logic                                  w_commit;
    logic [OUT_WIDTH-1:0]                  data_out;
    logic                                  valid;
    logic [15:0]                           ovf_cnt;

    modport master (
        output ena, data_dly, w_wr, w_addr, w_data, w_commit,
        input  data_out, valid, ovf_cnt
    );

    modport slave (
        input  ena, data_dly, w_wr, w_addr, w_data, w_commit,
        output data_out, valid, ovf_cnt
    );
endinterface

// File: rtl/crpa_stap_combiner.sv
// rtl/crpa_stap_combiner.sv - weighted Nin x NT tap combiner with double-buffered weights
// Optional output saturation and overflow counting: define CRPA_COMB_SAT_EN.
module crpa_stap_combiner #(
    parameter int Nin       = 8,
    parameter int in_width  = 14,
    parameter int NT        = 4,
    parameter int W_WIDTH   = 16,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 14
) (
    input logic              clk,
    input logic              resetn,
    crpa_stap_combiner_if.slave bus
);
    localparam int NW   = Nin * NT;
    localparam int LOG  = $clog2(NW);
    localparam int NPAD = 1 << LOG;
    localparam int F    = in_width + W_WIDTH + LOG;
    localparam logic signed [F:0] RND =
        (SHIFT > 0) ? ((F+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic signed [W_WIDTH-1:0] shadow [NW];
    logic signed [W_WIDTH-1:0] active [NW];
    logic signed [F-1:0]       prod   [NPAD];
    logic signed [F-1:0]       lvl    [LOG+1][NPAD];
    logic [LOG:0]              en_pipe;
    logic signed [F:0]         rounded;
    logic signed [F:0]         shifted;

    // A write landing on the commit edge is forwarded so it takes effect in the same swap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < NW; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            if (bus.w_wr && (int'(bus.w_addr) < NW))
                shadow[bus.w_addr] <= bus.w_data;
            if (bus.w_commit) begin
                for (int k = 0; k < NW; k++)
                    active[k] <= (bus.w_wr && int'(bus.w_addr) == k) ? bus.w_data : shadow[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NPAD; k++)
            prod[k] = '0;
        for (int k = 0; k < NW; k++)
            prod[k] = F'($signed(bus.data_dly[k/NT][k%NT])) * F'(active[k]);
    end

    // Products are registered once, then a binary tree halves the operand count per stage.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int s = 0; s <= LOG; s++)
                for (int i = 0; i < NPAD; i++)
                    lvl[s][i] <= '0;
            en_pipe <= '0;
        end else begin
            for (int i = 0; i < NPAD; i++)
                lvl[0][i] <= prod[i];
            for (int s = 1; s <= LOG; s++)
                for (int i = 0; i < (NPAD >> s); i++)
                    lvl[s][i] <= lvl[s-1][2*i] + lvl[s-1][2*i+1];
            en_pipe <= {en_pipe[LOG-1:0], bus.ena};
        end
    end

    always_comb begin
        rounded = {lvl[LOG][0][F-1], lvl[LOG][0]} + RND;
        shifted = rounded >>> SHIFT;
    end

`ifdef CRPA_COMB_SAT_EN
    localparam logic signed [F:0] OMAX = (F+1)'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [F:0] OMIN = -OMAX - (F+1)'(1);

    logic sat_hi;
    logic sat_lo;
    assign sat_hi = shifted > OMAX;
    assign sat_lo = shifted < OMIN;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.data_out <= '0;
            bus.valid    <= 1'b0;
            bus.ovf_cnt  <= '0;
        end else begin
            bus.valid    <= en_pipe[LOG];
            bus.data_out <= sat_hi ? OUT_WIDTH'(OMAX) :
                            sat_lo ? OUT_WIDTH'(OMIN) : OUT_WIDTH'(shifted);
            if (en_pipe[LOG] && (sat_hi || sat_lo) && bus.ovf_cnt != 16'hFFFF)
                bus.ovf_cnt <= bus.ovf_cnt + 16'd1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.data_out <= '0;
            bus.valid    <= 1'b0;
        end else begin
            bus.valid    <= en_pipe[LOG];
            bus.data_out <= OUT_WIDTH'(shifted);
        end
    end

    assign bus.ovf_cnt = '0;
`endif
endmodule

// File: doc/crpa_stap_combiner.md
# crpa_stap_combiner

Space-time weighted combiner for the CRPA chain: consumes the Nin×NT tapped-delay samples produced by the delay array, multiplies each tap by a programmable signed weight and sums all products into one output sample per clock. It has a double-buffered weight bank written by a simple write port, so new weights from the adaptation processor apply atomically between samples. It sits directly after the delay array and feeds the downstream correlator/DDC input.

## Interface
- Nin, 8, antenna ports
- in_width, 14, signed sample width
- NT, 4, taps per port
- W_WIDTH, 16, signed weight width
- OUT_WIDTH, 16, signed output width
- SHIFT, 14, right shift applied to the full-precision sum (0..in_width+W_WIDTH)
- clk  input  1  single clock for all logic
- resetn  input  1  synchronous active-low reset
- ena  input  1  data_dly holds a valid sample this cycle
- data_dly  input  adc_interf_3d (PORTS=Nin, GROUP=NT, R=in_width)  data[port][tap], tap 0 newest
- w_wr  input  1  write shadow weight
- w_addr  input  clog2(Nin*NT)  index = port*NT + tap
- w_data  input  W_WIDTH  signed weight
- w_commit  input  1  copy shadow bank to active bank
- data_out  output  OUT_WIDTH  signed combined sample
- valid  output  1  data_out valid
- ovf_cnt  output  16  saturation event count

## Operation
- Two banks of Nin*NT weights: shadow (write port) and active (used by datapath). Reset clears both to 0.
- w_wr=1: shadow[w_addr] <= w_data. w_addr ≥ Nin*NT: write ignored.
- w_commit=1: active <= shadow at that edge, including a w_wr landing in the same cycle. Independent of ena.
- Datapath: stage P registers p[k] = x[k]*active[k] (in_width+W_WIDTH bits, signed). Adder tree of clog2(Nin*NT) registered stages, each stage widening by 1 bit; full sum width F = in_width+W_WIDTH+clog2(Nin*NT) (35 by default).
- Output stage: if SHIFT>0 add 2^(SHIFT-1), arithmetic shift right by SHIFT, then reduce to OUT_WIDTH (see Configuration).
- ena is delayed alongside data; pipeline registers advance every cycle; valid = delayed ena. Samples with ena=0 still flow but are flagged invalid.

## Timing
- Reset values: data_out=0, valid=0, ovf_cnt=0, all pipeline registers 0, both banks 0.
- Latency L = 1 + clog2(Nin*NT) + 1 = 7 cycles (defaults) from sample edge to data_out/valid.
- Throughput: one sample per clock, no back-pressure.
- Commit at edge t: sample entering stage P at edge t+1 uses new weights; samples already in the tree finish with old weights (no mixed-bank sample ever produced).
- resetn low mid-operation: all state cleared at the next edge; valid low for L cycles after release.

## Configuration
- Macro CRPA_COMB_SAT_EN.
- Defined: shifted sum outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] clamps to the nearest bound; each saturated valid sample increments ovf_cnt, which sticks at 65535.
- Undefined: shifted sum truncated to low OUT_WIDTH bits (two's-complement wrap); ovf_cnt tied to 0; no comparison logic.

## Test plan
- Reset: hold resetn=0 3 cycles with ena=1, random data -> data_out=0, valid=0, ovf_cnt=0 throughout and for 7 cycles after release.
- Single tap: SHIFT=0, write shadow[1*NT+0]=1, commit, ramp port 1 by +1/cycle -> data_out equals port-1 tap-0 input delayed exactly 7 cycles, valid follows ena by 7.
- Atomic commit: all weights 1 active, write shadow all 2 without commit -> output unchanged; commit at edge t -> samples entering at t+1 and later doubled, earlier ones not.
- Rounding: SHIFT=1, one weight=1, input 3 -> out 2; input -3 -> out -1.
- Saturation (macro on): all weights 16384, all inputs 8191, SHIFT=14 -> sum 4294443008, data_out=32767, ovf_cnt increments per valid sample; all inputs -8192 -> data_out=-32768.
- Wrap (macro off): same stimulus as previous -> data_out = low 16 bits of 262112 (0xFFE0 = -32), ovf_cnt=0.
